// File: rtl/muxn_pkg.sv
// Shared types and helpers for the muxn_arb N-channel registered mux/arbiter.
package muxn_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational wrapped-priority picker: first set req at ptr, ptr+1, ..., wrapping mod NCH.
module rr_pick
    import muxn_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        int k;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NCH;
            if (req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(k);
            end
        end
    end

endmodule

// File: rtl/muxn_arb.sv
// N-channel registered mux with explicit-select or round-robin arbitration and one output stage.
// Optional registered even-parity output out_par when MUXN_PARITY_EN is defined.
module muxn_arb
    import muxn_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
`ifdef MUXN_PARITY_EN
    output logic                 out_par,
`endif
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic             load_en;
    logic             fire;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0]  next_ptr;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // An out-of-range select simply never grants.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (mode_e'(mode) == MODE_RR) begin
            grant_valid = rr_valid;
            grant       = rr_idx;
        end else if (int'(sel) < NCH) begin
            grant_valid = in_valid[sel];
            grant       = sel;
        end
    end

    assign load_en    = !out_valid || out_ready;
    assign fire       = load_en && grant_valid && !reset;
    assign grant_data = in_data[grant*WIDTH +: WIDTH];
    assign next_ptr   = (grant == SELW'(NCH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (fire) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
`ifdef MUXN_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant;
`ifdef MUXN_PARITY_EN
                out_par   <= ^grant_data;
`endif
                if (mode_e'(mode) == MODE_RR) begin
                    ptr <= next_ptr;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
